// File: rtl/std_sec_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : std_sec_pkg
//  Description : Bit-mapping helpers shared by the SEC encoder and decoder.
//                Codeword bit k-1 carries Hamming position k (1-based).
//                Parity bits sit at power-of-two positions. Data bits fill
//                the remaining positions in ascending order.
//  Revision    : 1.0 - initial release
// ============================================================================
package std_sec_pkg;

    // True when 1-based position k holds a parity bit
    function automatic bit sec_is_parity_pos(input int k);
        return (k > 0) && ((k & (k - 1)) == 0);
    endfunction

    // Ceiling log2. Written as a loop so that it stays a constant function.
    function automatic int sec_clog2(input int k);
        for (int r = 0; r < 31; r++) begin
            if ((1 << r) >= k) begin
                return r;
            end
        end
        return 31;
    endfunction

    // Data-word index of the non-parity 1-based position k.
    // Every power of two below k holds a parity bit, so clog2(k) parity
    // slots precede k.
    function automatic int sec_data_index(input int k);
        return k - sec_clog2(k) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/std_linear_sec_decoder_pipe_if.sv
`default_nettype none
// ============================================================================
//  Interface   : std_linear_sec_decoder_pipe_if
//  Description : Codeword input stream, decoded output stream and the
//                counter controls of the SEC decoder.
//  Ports (slave = decoder view):
//    i_valid / o_ready / i_codeword                     upstream codeword
//    o_valid / i_ready / o_word / o_syndrome
//    o_corrected / o_uncorrectable                      decoded stream
//    i_clear_count / o_corrected_count                  health counter
//  Revision    : 1.0 - initial release
// ============================================================================
interface std_linear_sec_decoder_pipe_if #(
    parameter int P     = 4,
    parameter int K     = (1 << P) - 1,
    parameter int N     = K - P,
    parameter int CNT_W = 16
);
    logic             i_valid;
    logic             o_ready;
    logic [K-1:0]     i_codeword;
    logic             o_valid;
    logic             i_ready;
    logic [N-1:0]     o_word;
    logic [P-1:0]     o_syndrome;
    logic             o_corrected;
    logic             o_uncorrectable;
    logic             i_clear_count;
    logic [CNT_W-1:0] o_corrected_count;

    // Upstream producer plus downstream consumer
    modport master (
        output i_valid, i_codeword, i_ready, i_clear_count,
        input  o_ready, o_valid, o_word, o_syndrome, o_corrected,
               o_uncorrectable, o_corrected_count
    );

    // Decoder
    modport slave (
        input  i_valid, i_codeword, i_ready, i_clear_count,
        output o_ready, o_valid, o_word, o_syndrome, o_corrected,
               o_uncorrectable, o_corrected_count
    );
endinterface
`default_nettype wire

// File: rtl/std_linear_sec_syndrome.sv
`default_nettype none
// ============================================================================
//  Module      : std_linear_sec_syndrome
//  Description : Combinational syndrome generator. The syndrome is the XOR of
//                the 1-based positions of all set codeword bits. A zero
//                syndrome means no error was detected.
//  Ports       : i_codeword [K-1:0]  received codeword
//                o_syndrome [P-1:0]  syndrome
//  Revision    : 1.0 - initial release
// ============================================================================
module std_linear_sec_syndrome #(
    parameter int P = 4,
    parameter int K = (1 << P) - 1
) (
    input  wire  [K-1:0] i_codeword,
    output logic [P-1:0] o_syndrome
);

    always_comb begin
        o_syndrome = '0;
        for (int k = 0; k < K; k++) begin
            if (i_codeword[k]) begin
                o_syndrome = o_syndrome ^ P'(k + 1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/std_linear_sec_decoder_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : std_linear_sec_decoder_pipe
//  Description : Streaming single-error-correcting Hamming decoder with a
//                two-stage registered pipeline. The decoder also has a
//                saturating counter of corrected words that have been
//                delivered downstream.
//  Ports       : i_clk  clock
//                i_rst  synchronous, active-low reset
//                bus    codeword in / decoded word out / counter (slave)
//  Revision    : 1.0 - initial release
// ============================================================================
module std_linear_sec_decoder_pipe
    import std_sec_pkg::*;
#(
    parameter int P     = 4,
    parameter int K     = (1 << P) - 1,
    parameter int N     = K - P,
    parameter int CNT_W = 16
) (
    input wire i_clk,
    input wire i_rst,
    std_linear_sec_decoder_pipe_if.slave bus
);

    localparam logic [P:0] c_k_limit = (P + 1)'(K);

    logic [P-1:0]     w_syn;
    logic [N-1:0]     w_in_data;
    logic [N-1:0]     w_flip;
    logic             w_uncorr;
    logic             w_corr;
    logic             w_s2_load;
    logic             w_in_ready;

    logic             r_s1_valid;
    logic [N-1:0]     r_s1_data;
    logic [P-1:0]     r_s1_syn;

    logic             r_out_valid;
    logic [N-1:0]     r_out_word;
    logic [P-1:0]     r_out_syn;
    logic             r_out_corr;
    logic             r_out_uncorr;
    logic [CNT_W-1:0] r_count;

    std_linear_sec_syndrome #(.P(P), .K(K)) u_syndrome (
        .i_codeword (bus.i_codeword),
        .o_syndrome (w_syn)
    );

    // After the syndrome is computed, the parity bits are no longer needed.
    // Stage 1 therefore keeps only the raw data bits. Stage 2 flips the data
    // bit whose Hamming position equals the syndrome. A syndrome that points
    // at a parity position, or that points beyond K, matches no data bit.
    // In that case the data passes through unchanged.
    for (genvar k = 1; k <= K; k++) begin : g_data
        if (!sec_is_parity_pos(k)) begin : g_bit
            assign w_in_data[sec_data_index(k)] = bus.i_codeword[k-1];
            assign w_flip[sec_data_index(k)]    = (r_s1_syn == P'(k));
        end
    end

    assign w_uncorr   = ({1'b0, r_s1_syn} > c_k_limit);
    assign w_corr     = (r_s1_syn != '0) && !w_uncorr;
    assign w_s2_load  = !r_out_valid || bus.i_ready;
    assign w_in_ready = !r_s1_valid || w_s2_load;

    // Stage 1
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_in_ready) begin
            r_s1_valid <= bus.i_valid;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_in_ready && bus.i_valid) begin
            r_s1_data <= w_in_data;
            r_s1_syn  <= w_syn;
        end
    end

    // Stage 2 (output). When stage 1 is empty, the data registers hold their
    // last value and only o_valid drops.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_out_valid  <= 1'b0;
            r_out_word   <= '0;
            r_out_syn    <= '0;
            r_out_corr   <= 1'b0;
            r_out_uncorr <= 1'b0;
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_word   <= r_s1_data ^ w_flip;
                r_out_syn    <= r_s1_syn;
                r_out_corr   <= w_corr;
                r_out_uncorr <= w_uncorr;
            end
        end
    end

    // Corrected-word counter. A clear overrides a coincident increment.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_count <= '0;
        end else if (bus.i_clear_count) begin
            r_count <= '0;
        end else if (r_out_valid && bus.i_ready && r_out_corr && !(&r_count)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign bus.o_ready           = w_in_ready;
    assign bus.o_valid           = r_out_valid;
    assign bus.o_word            = r_out_word;
    assign bus.o_syndrome        = r_out_syn;
    assign bus.o_corrected       = r_out_corr;
    assign bus.o_uncorrectable   = r_out_uncorr;
    assign bus.o_corrected_count = r_count;

endmodule
`default_nettype wire
